stack_ctrl: RTL and testbench
=============================

// Module: stack_ctrl
// PURPOSE
//  Sequencer for the 2-level 11-bit hardware return stack (stack1/stack2 shift pair).
//  Accepts one-cycle CALL/RETURN requests from the instruction decoder.
//  Drives the stack load strobes and the PC "load from stack" select.
//  Tracks stack depth and flags overflow/underflow; sits between decoder, PC unit and stack.
// PARAMETERS
//  STACK_DEPTH  2  number of stack levels; must match the stack datapath
//  CNT_W        2  depth counter width; must satisfy 2**CNT_W > STACK_DEPTH
// PORTS
//  clk             in   1  single system clock, rising edge
//  rst_n           in   1  asynchronous, active-low reset
//  call_req        in   1  push request, sampled only in IDLE
//  ret_req         in   1  pop request (RETLW), sampled only in IDLE
//  err_clr         in   1  clears sticky ovf/unf (STACK_ERR_EN only)
//  load_from_PC    out  1  stack1 <= PC_out this edge
//  load_from_stk1  out  1  stack2 <= stack1 this edge
//  load_from_stk2  out  1  stack1 <= stack2 this edge
//  pc_from_stack   out  1  PC unit loads stack_out this edge
//  busy            out  1  FSM not in IDLE
//  ack             out  1  one-cycle pulse on the final cycle of an operation
//  depth           out  CNT_W  current number of valid entries, 0..STACK_DEPTH
//  ovf             out  1  sticky: push attempted while depth==STACK_DEPTH
//  unf             out  1  sticky: pop attempted while depth==0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; depth=0; ovf=unf=0.
//   Takes effect immediately, including mid-operation; any partial pop is abandoned.
//   Stack data registers are never reset.
//  FSM states: IDLE, PUSH, POP_RD, POP_SH. All strobes are Moore outputs decoded from state.
//  IDLE
//   call_req=1                -> PUSH (call has priority if call_req and ret_req are both 1).
//   ret_req=1 and call_req=0  -> POP_RD.
//   Otherwise                 -> stay in IDLE; requests are ignored while busy=1, never queued.
//  PUSH (1 cycle)
//   load_from_PC=1 and load_from_stk1=1 together, so both levels shift in a single edge.
//   ack=1; depth <= min(depth+1, STACK_DEPTH).
//   At depth==STACK_DEPTH: the shift still happens, the oldest entry is lost, depth holds, ovf <= 1.
//   Next state: IDLE.
//  POP_RD (1 cycle)
//   pc_from_stack=1; the PC captures stack1 before the shift.
//   Next state: POP_SH.
//  POP_SH (1 cycle)
//   load_from_stk2=1; stack2 keeps its value (level duplicates downward).
//   ack=1; depth <= depth-1, saturating at 0.
//   At depth==0: the pop still executes (stale data returned), depth holds 0, unf <= 1.
//   Next state: IDLE.
//  Latency, request to ack: push 1 cycle, pop 2 cycles.
//   New request accepted the cycle after ack (back-to-back throughput: push 1/cycle pair, pop 1 per 3).
//  Strobe exclusivity: load_from_stk2 is never high with load_from_PC or load_from_stk1.
//  Depth arithmetic is unsigned and saturating; no wrap-around in either direction.
// CONFIGURATION
//  STACK_ERR_EN defined:
//   ovf/unf are sticky registers set as above.
//   err_clr=1 clears both on the next edge; a set event in the same cycle wins over clear.
//  STACK_ERR_EN undefined:
//   ovf=unf=0 constant; err_clr ignored; no flag registers.
//   Saturating depth and overflow/underflow data behaviour are unchanged.
// TESTING
//  1. Reset, then call_req pulse
//     -> next cycle load_from_PC=load_from_stk1=ack=1; then depth=1, busy=0.
//  2. Push 0x123, push 0x456, ret
//     -> POP_RD: pc_from_stack=1 with stack_out=0x456; POP_SH: load_from_stk2=1.
//     -> After POP_SH: depth=1, stack_out=0x123.
//  3. Three pushes from depth 0
//     -> depth 1,2,2; ovf=1 after the third push (STACK_ERR_EN); err_clr=1 -> ovf=0.
//  4. ret_req at depth 0
//     -> full 2-cycle pop sequence runs; depth stays 0; unf=1 (STACK_ERR_EN), 0 otherwise.
//  5. call_req=ret_req=1 in IDLE
//     -> PUSH taken, no pc_from_stack; a ret_req held during PUSH is ignored.
//  6. rst_n=0 during POP_SH
//     -> all strobes 0 immediately; depth=0; after release state=IDLE, busy=0.

Source files
------------

// File: rtl/stack_ctrl.sv
// Call/return sequencer for the 2-level 11-bit hardware return stack.
// Optional sticky overflow/underflow flags are built only when STACK_ERR_EN is defined.
module stack_ctrl #(
  parameter int unsigned STACK_DEPTH = 2,
  parameter int unsigned CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             call_req_i,
  input  logic             ret_req_i,
  input  logic             err_clr_i,
  output logic             load_from_pc_o,
  output logic             load_from_stk1_o,
  output logic             load_from_stk2_o,
  output logic             pc_from_stack_o,
  output logic             busy_o,
  output logic             ack_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [CNT_W-1:0] DepthMax = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPush  = 2'd1,
    StPopRd = 2'd2,
    StPopSh = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             ovf_set, unf_set;

  always_comb begin
    state_d          = state_q;
    depth_d          = depth_q;
    ovf_set          = 1'b0;
    unf_set          = 1'b0;
    load_from_pc_o   = 1'b0;
    load_from_stk1_o = 1'b0;
    load_from_stk2_o = 1'b0;
    pc_from_stack_o  = 1'b0;
    ack_o            = 1'b0;
    busy_o           = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // Call wins when both requests arrive together.
        if (call_req_i) begin
          state_d = StPush;
        end else if (ret_req_i) begin
          state_d = StPopRd;
        end
      end
      StPush: begin
        load_from_pc_o   = 1'b1;
        load_from_stk1_o = 1'b1;
        ack_o            = 1'b1;
        if (depth_q >= DepthMax) begin
          ovf_set = 1'b1;
        end else begin
          depth_d = depth_q + 1'b1;
        end
        state_d = StIdle;
      end
      StPopRd: begin
        pc_from_stack_o = 1'b1;
        state_d         = StPopSh;
      end
      StPopSh: begin
        load_from_stk2_o = 1'b1;
        ack_o            = 1'b1;
        if (depth_q == '0) begin
          unf_set = 1'b1;
        end else begin
          depth_d = depth_q - 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
    end
  end

  assign depth_o = depth_q;

`ifdef STACK_ERR_EN
  logic ovf_q, unf_q;

  // A set event in the same cycle as err_clr takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (err_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (err_clr_i) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign ovf_o = ovf_q;
  assign unf_o = unf_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr_i, ovf_set, unf_set};
  assign ovf_o      = 1'b0;
  assign unf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a scoreboard of per-cycle expectations and a
// behavioural stack datapath driven by the DUT strobes.
module tb_stack_ctrl;

  localparam int Depth = 2;
`ifdef STACK_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk, rst_n, call_req, ret_req, err_clr;
  logic       load_from_pc, load_from_stk1, load_from_stk2, pc_from_stack;
  logic       busy, ack, ovf, unf;
  logic [1:0] depth;
  logic [10:0] pc_val, stk1, stk2, pc_reg;

  stack_ctrl #(.STACK_DEPTH(2), .CNT_W(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .call_req_i       (call_req),
    .ret_req_i        (ret_req),
    .err_clr_i        (err_clr),
    .load_from_pc_o   (load_from_pc),
    .load_from_stk1_o (load_from_stk1),
    .load_from_stk2_o (load_from_stk2),
    .pc_from_stack_o  (pc_from_stack),
    .busy_o           (busy),
    .ack_o            (ack),
    .depth_o          (depth),
    .ovf_o            (ovf),
    .unf_o            (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack datapath and PC capture register; data is never reset.
  always @(posedge clk) begin
    if (load_from_pc)   stk1 <= pc_val;
    if (load_from_stk1) stk2 <= stk1;
    if (load_from_stk2) stk1 <= stk2;
    if (pc_from_stack)  pc_reg <= stk1;
  end

  typedef struct {
    logic [3:0]  strb;   // {load_from_pc, load_from_stk1, load_from_stk2, pc_from_stack}
    logic        ack;
    logic        busy;
    int          depth;
    logic        ovf;
    logic        unf;
    bit          top_v;
    logic [10:0] top;
    bit          pc_v;
    logic [10:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          r_depth;
  bit          r_ovf, r_unf, r_v1, r_v2, r_pcv;
  logic [10:0] r_s1, r_s2, r_pc;

  function automatic exp_t snap(input logic [3:0] strb, input logic a, input logic b);
    exp_t e;
    e.strb  = strb;
    e.ack   = a;
    e.busy  = b;
    e.depth = r_depth;
    e.ovf   = r_ovf;
    e.unf   = r_unf;
    e.top_v = r_v1;
    e.top   = r_s1;
    e.pc_v  = r_pcv;
    e.pc    = r_pc;
    return e;
  endfunction

  function automatic void ref_clr(input bit clr);
    if (ErrEn && clr) begin
      r_ovf = 1'b0;
      r_unf = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_entry(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_strb"}, 32'({load_from_pc, load_from_stk1, load_from_stk2, pc_from_stack}),
        32'(e.strb));
    chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
    chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
    chk({tag, "_depth"}, 32'(depth), 32'(e.depth));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(e.unf));
    if (e.top_v) chk({tag, "_top"}, 32'(stk1), 32'(e.top));
    if (e.pc_v) chk({tag, "_pc"}, 32'(pc_reg), 32'(e.pc));
  endtask

  // Entered on a falling edge with the DUT idle; leaves on the falling edge after ack.
  task automatic run_op(input bit c, input bit r, input bit hold_ret, input bit hold_clr,
                        input logic [10:0] pcv, input string tag);
    bit set;
    call_req = c;
    ret_req  = r;
    err_clr  = hold_clr;
    pc_val   = pcv;
    ref_clr(hold_clr);
    if (c) begin
      sb.push_back(snap(4'b1100, 1'b1, 1'b1));
      set = (r_depth == Depth);
      ref_clr(hold_clr);
      if (ErrEn && set) r_ovf = 1'b1;
      if (!set) r_depth++;
      r_s2 = r_s1;
      r_v2 = r_v1;
      r_s1 = pcv;
      r_v1 = 1'b1;
    end else begin
      sb.push_back(snap(4'b0001, 1'b0, 1'b1));
      r_pc  = r_s1;
      r_pcv = r_v1;
      ref_clr(hold_clr);
      sb.push_back(snap(4'b0010, 1'b1, 1'b1));
      set = (r_depth == 0);
      ref_clr(hold_clr);
      if (ErrEn && set) r_unf = 1'b1;
      if (!set) r_depth--;
      r_s1 = r_s2;
      r_v1 = r_v2;
    end
    sb.push_back(snap(4'b0000, 1'b0, 1'b0));
    while (sb.size() > 0) begin
      @(negedge clk);
      call_req = 1'b0;
      if (sb.size() == 1) begin
        ret_req = 1'b0;
        err_clr = 1'b0;
      end else begin
        ret_req = hold_ret;
      end
      check_entry(tag);
    end
  endtask

  task automatic clr_only(input string tag);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    ref_clr(1'b1);
    chk({tag, "_ovf"}, 32'(ovf), 32'(r_ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(r_unf));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    rst_n    = 1'b0;
    call_req = 1'b0;
    ret_req  = 1'b0;
    err_clr  = 1'b0;
    pc_val   = '0;
    r_depth  = 0;
    r_ovf    = 1'b0;
    r_unf    = 1'b0;
    r_v1     = 1'b0;
    r_v2     = 1'b0;
    r_pcv    = 1'b0;
    r_s1     = '0;
    r_s2     = '0;
    r_pc     = '0;

    repeat (2) @(negedge clk);
    sb.push_back(snap(4'b0000, 1'b0, 1'b0));
    check_entry("reset");
    rst_n = 1'b1;

    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h0AA, "t1_call");
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, "t1_ret");

    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h123, "t2_push_a");
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h456, "t2_push_b");
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, "t2_ret");
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, "t2_ret_last");

    run_op(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, "t4_ret_empty");
    clr_only("t4_clr");

    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h111, "t3_push1");
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h222, "t3_push2");
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h333, "t3_push3");
    clr_only("t3_clr");
    run_op(1'b1, 1'b0, 1'b0, 1'b1, 11'h444, "t3_set_wins");

    run_op(1'b1, 1'b1, 1'b1, 1'b0, 11'h555, "t5_both");
    clr_only("t5_clr");
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 11'h000, "t5_ret");

    // Reset in the middle of a pop: abandoned before the shift edge.
    ret_req = 1'b1;
    @(negedge clk);
    ret_req = 1'b0;
    chk("t6_pop_rd", 32'(pc_from_stack), 32'(1));
    r_pc  = r_s1;
    r_pcv = r_v1;
    @(negedge clk);
    chk("t6_pop_sh", 32'(load_from_stk2), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_strb", 32'({load_from_pc, load_from_stk1, load_from_stk2, pc_from_stack}),
        32'(0));
    chk("t6_rst_ack", 32'(ack), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_depth", 32'(depth), 32'(0));
    chk("t6_rst_flags", 32'({ovf, unf}), 32'(0));
    r_depth = 0;
    r_ovf   = 1'b0;
    r_unf   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_busy", 32'(busy), 32'(0));
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 11'h0F0, "t6_push_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
